// File: rtl/icc_branch_unit.sv
// Integer condition-code register and Bicc branch resolver.
// Holds {N,Z,V,C}, evaluates Bicc conditions and sequences the delay-slot annul.
module icc_branch_unit #(
    parameter bit         BYPASS_EN = 1'b1,
    parameter logic [3:0] ICC_RESET = 4'b0000
) (
    input  logic       Clk,
    input  logic       Reset_N,
    input  logic       ALU_N,
    input  logic       ALU_Z,
    input  logic       ALU_V,
    input  logic       ALU_C,
    input  logic [5:0] Opcode,
    input  logic       Exec_Valid,
    input  logic       Wr_Icc,
    input  logic [3:0] Wr_Icc_Data,
    input  logic       Branch_Valid,
    input  logic [3:0] Branch_Cond,
    input  logic       Branch_Annul,
    output logic       C_In,
    output logic [3:0] Icc,
    output logic       Branch_Stall,
    output logic       Branch_Taken,
    output logic       Annul_Slot,
    output logic       Dcti_Err
);

    typedef enum logic [1:0] {
        RUN,
        SLOT,
        ANNUL
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] icc_q;
    logic [3:0] icc_d;
    logic [3:0] alu_flags;
    logic [3:0] ev_flags;
    logic       cc_wr;
    logic       in_run;
    logic       accept;
    logic       dcti;
    logic       base;
    logic       taken;
    logic       annul;
    logic       f_n;
    logic       f_z;
    logic       f_v;
    logic       f_c;
    logic       unused_opcode;

    assign unused_opcode = ^Opcode[3:0];

    assign alu_flags = {ALU_N, ALU_Z, ALU_V, ALU_C};
    assign cc_wr     = Exec_Valid & (Opcode[5:4] == 2'b01);
    assign ev_flags  = (BYPASS_EN && cc_wr) ? alu_flags : icc_q;
    assign {f_n, f_z, f_v, f_c} = ev_flags;

    // A delay slot in flight never stalls; a stray branch there is a DCTI.
    assign in_run       = (state_q == RUN);
    assign Branch_Stall = !BYPASS_EN && Branch_Valid && cc_wr && in_run;
    assign accept       = Branch_Valid && !Branch_Stall && in_run;
    assign dcti         = Branch_Valid && !in_run;

    always_comb begin
        base = 1'b0;
        unique case (Branch_Cond[2:0])
            3'b000: base = 1'b0;
            3'b001: base = f_z;
            3'b010: base = f_z | (f_n ^ f_v);
            3'b011: base = f_n ^ f_v;
            3'b100: base = f_c | f_z;
            3'b101: base = f_c;
            3'b110: base = f_n;
            3'b111: base = f_v;
            default: base = 1'b0;
        endcase
        taken = base ^ Branch_Cond[3];
    end

    assign annul = Branch_Annul & (!taken | (Branch_Cond == 4'b1000));

    always_comb begin
        icc_d = icc_q;
        if (cc_wr) begin
            icc_d = alu_flags;
        end else if (Wr_Icc) begin
            icc_d = Wr_Icc_Data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    state_d = annul ? ANNUL : SLOT;
                end
            end
            SLOT:    state_d = RUN;
            ANNUL:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            icc_q        <= ICC_RESET;
            state_q      <= RUN;
            Branch_Taken <= 1'b0;
            Annul_Slot   <= 1'b0;
            Dcti_Err     <= 1'b0;
        end else begin
            icc_q        <= icc_d;
            state_q      <= state_d;
            Branch_Taken <= accept & taken;
            Annul_Slot   <= accept & annul;
            Dcti_Err     <= dcti;
        end
    end

    assign Icc  = icc_q;
    assign C_In = icc_q[0];

endmodule

// File: tb/tb_icc_branch_unit.sv
// Bench for icc_branch_unit: bypass and stall variants side by side
// against a cycle-level behavioural model of the icc and Bicc rules.
module tb_icc_branch_unit;

    logic       clk;
    logic       rst_n;
    logic       alu_n, alu_z, alu_v, alu_c;
    logic [5:0] opcode;
    logic       ex_valid;
    logic       wr_icc;
    logic [3:0] wr_data;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_annul;

    logic [1:0]      c_in_o, stall_o, taken_o, annul_o, dcti_o;
    logic [1:0][3:0] icc_o;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_icc;
    bit   [1:0] m_busy;
    logic [1:0] e_taken, e_annul, e_dcti;

    icc_branch_unit #(.BYPASS_EN(1'b1), .ICC_RESET(4'b0000)) dut_b1 (
        .Clk(clk), .Reset_N(rst_n),
        .ALU_N(alu_n), .ALU_Z(alu_z), .ALU_V(alu_v), .ALU_C(alu_c),
        .Opcode(opcode), .Exec_Valid(ex_valid),
        .Wr_Icc(wr_icc), .Wr_Icc_Data(wr_data),
        .Branch_Valid(br_valid), .Branch_Cond(br_cond),
        .Branch_Annul(br_annul),
        .C_In(c_in_o[1]), .Icc(icc_o[1]), .Branch_Stall(stall_o[1]),
        .Branch_Taken(taken_o[1]), .Annul_Slot(annul_o[1]),
        .Dcti_Err(dcti_o[1])
    );

    icc_branch_unit #(.BYPASS_EN(1'b0), .ICC_RESET(4'b0000)) dut_b0 (
        .Clk(clk), .Reset_N(rst_n),
        .ALU_N(alu_n), .ALU_Z(alu_z), .ALU_V(alu_v), .ALU_C(alu_c),
        .Opcode(opcode), .Exec_Valid(ex_valid),
        .Wr_Icc(wr_icc), .Wr_Icc_Data(wr_data),
        .Branch_Valid(br_valid), .Branch_Cond(br_cond),
        .Branch_Annul(br_annul),
        .C_In(c_in_o[0]), .Icc(icc_o[0]), .Branch_Stall(stall_o[0]),
        .Branch_Taken(taken_o[0]), .Annul_Slot(annul_o[0]),
        .Dcti_Err(dcti_o[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_taken(logic [3:0] cond, logic [3:0] f);
        bit n, z, v, c;
        {n, z, v, c} = f;
        case (cond)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b1001: return !z;
            4'b0001: return z;
            4'b1010: return !(z || (n != v));
            4'b0010: return z || (n != v);
            4'b1011: return n == v;
            4'b0011: return n != v;
            4'b1100: return !(c || z);
            4'b0100: return c || z;
            4'b1101: return !c;
            4'b0101: return c;
            4'b1110: return !n;
            4'b0110: return n;
            4'b1111: return !v;
            default: return v;
        endcase
    endfunction

    function automatic bit model_cc();
        return ex_valid && (opcode[5:4] == 2'b01);
    endfunction

    function automatic logic [1:0] model_stall();
        logic [1:0] s;
        s[1] = 1'b0;
        s[0] = br_valid && model_cc() && !m_busy[0];
        return s;
    endfunction

    task automatic set_alu(input logic [3:0] f);
        {alu_n, alu_z, alu_v, alu_c} = f;
    endtask

    task automatic idle_inputs();
        set_alu(4'b0000);
        opcode   = 6'b000000;
        ex_valid = 1'b0;
        wr_icc   = 1'b0;
        wr_data  = 4'b0000;
        br_valid = 1'b0;
        br_cond  = 4'b0000;
        br_annul = 1'b0;
    endtask

    // One clock: advance the model from the current inputs, then the DUT.
    task automatic cyc();
        bit         cc, acc, tk;
        logic [3:0] alu, fl;
        logic [1:0] st;
        cc  = model_cc();
        alu = {alu_n, alu_z, alu_v, alu_c};
        st  = model_stall();
        for (int b = 0; b < 2; b++) begin
            fl  = (b == 1 && cc) ? alu : m_icc;
            acc = br_valid && !m_busy[b] && !st[b];
            tk  = cond_taken(br_cond, fl);
            e_taken[b] = acc && tk;
            e_annul[b] = acc && br_annul && (!tk || br_cond == 4'b1000);
            e_dcti[b]  = br_valid && m_busy[b];
            m_busy[b]  = acc;
        end
        if (cc) m_icc = alu;
        else if (wr_icc) m_icc = wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic write_icc(input logic [3:0] v);
        idle_inputs();
        wr_icc  = 1'b1;
        wr_data = v;
        cyc();
        wr_icc  = 1'b0;
    endtask

    task automatic model_reset();
        m_icc   = 4'b0000;
        m_busy  = 2'b00;
        e_taken = 2'b00;
        e_annul = 2'b00;
        e_dcti  = 2'b00;
    endtask

    task automatic test_reset();
        write_icc(4'b1010);
        br_valid = 1'b1;
        br_cond  = 4'b1000;
        cyc();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (icc_o !== 8'h00 || c_in_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_icc icc=%h c_in=%b want 00/00",
                     icc_o, c_in_o);
        end
        checks++;
        if ({taken_o, annul_o, dcti_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_pulses t=%b a=%b d=%b want 0",
                     taken_o, annul_o, dcti_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({taken_o, annul_o, dcti_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_release t=%b a=%b d=%b want 0",
                     taken_o, annul_o, dcti_o);
        end
        br_valid = 1'b1;
        br_cond  = 4'b1000;
        cyc();
        checks++;
        if (taken_o !== 2'b11 || dcti_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_accept taken=%b dcti=%b want 11/00",
                     taken_o, dcti_o);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_capture();
        idle_inputs();
        opcode   = 6'b010000;
        ex_valid = 1'b1;
        set_alu(4'b1001);
        cyc();
        checks++;
        if (icc_o !== {2{4'b1001}} || c_in_o !== 2'b11) begin
            failures++;
            $display("FAIL capture_cc icc=%h c_in=%b want 99/11",
                     icc_o, c_in_o);
        end
        opcode = 6'b100101;
        set_alu(4'b0110);
        cyc();
        checks++;
        if (icc_o !== {2{4'b1001}}) begin
            failures++;
            $display("FAIL capture_shift icc=%h want 99", icc_o);
        end
        opcode   = 6'b010000;
        ex_valid = 1'b0;
        cyc();
        checks++;
        if (icc_o !== {2{4'b1001}}) begin
            failures++;
            $display("FAIL capture_bubble icc=%h want 99", icc_o);
        end
        write_icc(4'b0010);
        checks++;
        if (icc_o !== {2{4'b0010}} || c_in_o !== 2'b00) begin
            failures++;
            $display("FAIL capture_wr icc=%h c_in=%b want 22/00",
                     icc_o, c_in_o);
        end
    endtask

    task automatic test_bypass();
        write_icc(4'b0000);
        opcode   = 6'b010100;
        ex_valid = 1'b1;
        set_alu(4'b0100);
        br_valid = 1'b1;
        br_cond  = 4'b0001;
        br_annul = 1'b0;
        #1;
        checks++;
        if (stall_o !== 2'b01) begin
            failures++;
            $display("FAIL bypass_stall stall=%b want 01", stall_o);
        end
        cyc();
        checks++;
        if (taken_o !== 2'b10 || annul_o !== 2'b00) begin
            failures++;
            $display("FAIL bypass_fwd taken=%b annul=%b want 10/00",
                     taken_o, annul_o);
        end
        ex_valid = 1'b0;
        #1;
        checks++;
        if (stall_o !== 2'b00) begin
            failures++;
            $display("FAIL bypass_restall stall=%b want 00", stall_o);
        end
        cyc();
        checks++;
        if (taken_o !== 2'b01 || dcti_o !== 2'b10) begin
            failures++;
            $display("FAIL bypass_retry taken=%b dcti=%b want 01/10",
                     taken_o, dcti_o);
        end
        idle_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_annul();
        write_icc(4'b0100);
        br_valid = 1'b1;
        br_cond  = 4'b1001;
        br_annul = 1'b1;
        cyc();
        checks++;
        if (taken_o !== 2'b00 || annul_o !== 2'b11) begin
            failures++;
            $display("FAIL annul_bne taken=%b annul=%b want 00/11",
                     taken_o, annul_o);
        end
        idle_inputs();
        cyc();
        checks++;
        if (annul_o !== 2'b00) begin
            failures++;
            $display("FAIL annul_pulse annul=%b want 00", annul_o);
        end
        br_valid = 1'b1;
        br_cond  = 4'b1000;
        br_annul = 1'b1;
        cyc();
        checks++;
        if (taken_o !== 2'b11 || annul_o !== 2'b11) begin
            failures++;
            $display("FAIL annul_ba taken=%b annul=%b want 11/11",
                     taken_o, annul_o);
        end
        write_icc(4'b1000);
        br_valid = 1'b1;
        br_cond  = 4'b0011;
        br_annul = 1'b1;
        cyc();
        checks++;
        if (taken_o !== 2'b11 || annul_o !== 2'b00) begin
            failures++;
            $display("FAIL annul_bl taken=%b annul=%b want 11/00",
                     taken_o, annul_o);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_sweep();
        bit tk;
        for (int f = 0; f < 16; f++) begin
            write_icc(4'(f));
            for (int c = 0; c < 16; c++) begin
                tk       = cond_taken(4'(c), 4'(f));
                br_valid = 1'b1;
                br_cond  = 4'(c);
                br_annul = 1'($urandom_range(0, 1));
                cyc();
                checks++;
                if (taken_o !== {tk, tk} || annul_o !== e_annul) begin
                    failures++;
                    $display("FAIL sweep c=%h f=%h t=%b a=%b want %b/%b",
                             c, f, taken_o, annul_o, {tk, tk}, e_annul);
                end
                br_valid = 1'b0;
                cyc();
            end
        end
    endtask

    task automatic test_corner();
        idle_inputs();
        br_valid = 1'b1;
        br_cond  = 4'b1000;
        cyc();
        br_cond = 4'b1001;
        cyc();
        checks++;
        if (dcti_o !== 2'b11 || taken_o !== 2'b00) begin
            failures++;
            $display("FAIL dcti dcti=%b taken=%b want 11/00",
                     dcti_o, taken_o);
        end
        br_cond = 4'b1000;
        cyc();
        checks++;
        if (taken_o !== 2'b11 || dcti_o !== 2'b00) begin
            failures++;
            $display("FAIL dcti_next taken=%b dcti=%b want 11/00",
                     taken_o, dcti_o);
        end
        idle_inputs();
        cyc();
        opcode   = 6'b011111;
        ex_valid = 1'b1;
        set_alu(4'b0010);
        wr_icc   = 1'b1;
        wr_data  = 4'b1111;
        cyc();
        checks++;
        if (icc_o !== {2{4'b0010}}) begin
            failures++;
            $display("FAIL cc_over_wr icc=%h want 22", icc_o);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2000; i++) begin
            opcode   = 6'($urandom);
            ex_valid = 1'($urandom_range(0, 1));
            set_alu(4'($urandom));
            wr_icc   = ($urandom_range(0, 3) == 0);
            wr_data  = 4'($urandom);
            br_valid = ($urandom_range(0, 1) == 1);
            br_cond  = 4'($urandom);
            br_annul = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (stall_o !== model_stall()) begin
                failures++;
                $display("FAIL rnd_stall i=%0d got=%b want=%b",
                         i, stall_o, model_stall());
            end
            cyc();
            checks++;
            if (taken_o !== e_taken || annul_o !== e_annul ||
                dcti_o !== e_dcti) begin
                failures++;
                $display("FAIL rnd_pulse i=%0d t=%b a=%b d=%b want %b %b %b",
                         i, taken_o, annul_o, dcti_o,
                         e_taken, e_annul, e_dcti);
            end
            checks++;
            if (icc_o !== {m_icc, m_icc} || c_in_o !== {2{m_icc[0]}}) begin
                failures++;
                $display("FAIL rnd_icc i=%0d icc=%h c_in=%b want %h",
                         i, icc_o, c_in_o, m_icc);
            end
        end
        idle_inputs();
        cyc();
        cyc();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (icc_o !== 8'h00 || {taken_o, annul_o, dcti_o} !== 6'b0) begin
            failures++;
            $display("FAIL por icc=%h t=%b a=%b d=%b want 0",
                     icc_o, taken_o, annul_o, dcti_o);
        end
        rst_n = 1'b1;
        cyc();
        test_reset();
        test_capture();
        test_bypass();
        test_annul();
        test_sweep();
        test_corner();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
